// File: rtl/score_update_arbiter_pkg.sv
// Shared types and constants for the score update arbiter.
// Digit geometry, FSM encoding and the digit increment rule.
package score_update_arbiter_pkg;

   localparam int DIG_W = 4;
   localparam int DIG_N = 4;
   localparam int NUM_W = DIG_W * DIG_N;

   localparam logic [NUM_W-1:0] RESET_VAL_DEF = 16'h1234;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   // Returns {wrap, next_digit}; decimal mode folds 9 and A-F to 0.
   function automatic logic [DIG_W:0] inc_digit(
      input logic [DIG_W-1:0] x,
      input logic             dec
   );
      logic [DIG_W:0] r;
      if (dec) begin
         r = (x >= 4'd9) ? 5'b1_0000 : {1'b0, x + 4'd1};
      end else begin
         r = (x == 4'hF) ? 5'b1_0000 : {1'b0, x + 4'd1};
      end
      return r;
   endfunction

endpackage

// File: rtl/score_update_arbiter_if.sv
// Button/score bus between the arbiter and its environment.
// master drives the buttons and controls, slave is the arbiter.
interface score_update_arbiter_if;
   import score_update_arbiter_pkg::*;

   logic [DIG_N-1:0] btn_db;
   logic             mode_dec;
   logic             clr;
   logic [NUM_W-1:0] num;
   logic             busy;
   logic             upd_valid;
   logic [1:0]       upd_idx;
   logic             wrap;

   modport master (
      output btn_db, mode_dec, clr,
      input  num, busy, upd_valid, upd_idx, wrap
   );

   modport slave (
      input  btn_db, mode_dec, clr,
      output num, busy, upd_valid, upd_idx, wrap
   );

endinterface

// File: rtl/rr_arb4.sv
// Four-way round-robin selector.
// Grants the first pending bit at or above ptr, wrapping modulo 4.
module rr_arb4 (
   input  logic [3:0] pend,
   input  logic [1:0] ptr,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid
);

   logic [1:0] idx;
   logic       found;

   // scan upward from ptr and keep the first hit
   always_comb begin
      gnt_idx = ptr;
      found   = 1'b0;
      idx     = ptr;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && pend[idx]) begin
            gnt_idx = idx;
            found   = 1'b1;
         end
      end
      gnt_valid = found;
   end

endmodule

// File: rtl/score_update_arbiter.sv
// Four-digit score register updated by button presses.
// Rising buttons queue requests; a round-robin FSM commits one digit at a time.
module score_update_arbiter
   import score_update_arbiter_pkg::*;
#(
   parameter logic [NUM_W-1:0] RESET_VAL = RESET_VAL_DEF
) (
   input logic                   clk,
   input logic                   rst,
   score_update_arbiter_if.slave bus
);

   state_t           state;
   logic [DIG_N-1:0] btn_q;
   logic [DIG_N-1:0] pend;
   logic [DIG_N-1:0] rise;
   logic [DIG_N-1:0] done_mask;
   logic             armed;
   logic [1:0]       ptr;
   logic [1:0]       g;
   logic [1:0]       gnt_idx;
   logic             gnt_valid;
   logic [DIG_W-1:0] operand;
   logic [NUM_W-1:0] num_q;
   logic [DIG_W:0]   nxt;
   logic             upd_valid_q;
   logic [1:0]       upd_idx_q;
   logic             wrap_q;

   // armed masks the first edge after reset so held buttons need a new press
   assign rise      = bus.btn_db & ~btn_q & {DIG_N{armed}};
   assign done_mask = (state == COMMIT) ? (DIG_N'(1) << g) : '0;
   assign nxt       = inc_digit(operand, bus.mode_dec);

   assign bus.num       = num_q;
   assign bus.busy      = (state != IDLE);
   assign bus.upd_valid = upd_valid_q;
   assign bus.upd_idx   = upd_idx_q;
   assign bus.wrap      = wrap_q;

   rr_arb4 u_arb (
      .pend      (pend),
      .ptr       (ptr),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid)
   );

   // edge detect and pending request set; a new rise beats the commit clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_q <= '0;
         armed <= 1'b0;
         pend  <= '0;
      end else begin
         btn_q <= bus.btn_db;
         armed <= 1'b1;
         if (bus.clr) begin
            pend <= '0;
         end else begin
            pend <= (pend & ~done_mask) | rise;
         end
      end
   end

   // grant, load, commit sequencer with registered update strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         g           <= '0;
         operand     <= '0;
         num_q       <= RESET_VAL;
         ptr         <= '0;
         upd_valid_q <= 1'b0;
         upd_idx_q   <= '0;
         wrap_q      <= 1'b0;
      end else begin
         upd_valid_q <= 1'b0;
         wrap_q      <= 1'b0;
         if (bus.clr) begin
            num_q <= '0;
            state <= IDLE;
         end else begin
            unique case (state)
               IDLE: begin
                  if (gnt_valid) begin
                     g     <= gnt_idx;
                     state <= LOAD;
                  end
               end
               LOAD: begin
                  operand <= num_q[{g, 2'b00} +: DIG_W];
                  state   <= COMMIT;
               end
               COMMIT: begin
                  num_q[{g, 2'b00} +: DIG_W] <= nxt[DIG_W-1:0];
                  ptr         <= g + 2'd1;
                  upd_valid_q <= 1'b1;
                  upd_idx_q   <= g;
                  wrap_q      <= nxt[DIG_W];
                  state       <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_score_update_arbiter.sv
// Directed bench for score_update_arbiter.
// Stimulus queues expected updates; a monitor pops them on each upd_valid.
module tb_score_update_arbiter;

   typedef struct {
      logic [1:0]  idx;
      logic        w;
      logic [15:0] num;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   cyc;
   exp_t sb[$];
   exp_t mon_e;

   score_update_arbiter_if bus ();

   score_update_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   task automatic expect_upd(input logic [1:0] idx, input logic w,
                             input logic [15:0] num, input int dly);
      exp_t e;
      e.idx = idx;
      e.w   = w;
      e.num = num;
      e.cyc = cyc + dly;
      sb.push_back(e);
   endtask

   // one isolated press; commit lands 4 cycles after the rise
   task automatic press1(input int idx, input logic dec,
                         input logic [15:0] num, input logic w);
      @(negedge clk);
      bus.btn_db   = 4'(1 << idx);
      bus.mode_dec = dec;
      expect_upd(2'(idx), w, num, 4);
      @(negedge clk);
      bus.btn_db = 4'b0000;
      repeat (5) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // monitor: every update strobe must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && bus.upd_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_upd: got idx=%0d num=%h, required no update",
                     bus.upd_idx, bus.num);
         end else begin
            mon_e = sb.pop_front();
            chk("upd_idx", 32'(bus.upd_idx), 32'(mon_e.idx));
            chk("wrap", 32'(bus.wrap), 32'(mon_e.w));
            chk("num", 32'(bus.num), 32'(mon_e.num));
            chk("latency_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks       = 0;
      errors       = 0;
      rst          = 1'b1;
      bus.btn_db   = 4'b0000;
      bus.mode_dec = 1'b0;
      bus.clr      = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_num", 32'(bus.num), 32'h1234);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_upd_valid", 32'(bus.upd_valid), 32'h0);
      chk("rst_upd_idx", 32'(bus.upd_idx), 32'h0);
      chk("rst_wrap", 32'(bus.wrap), 32'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single press of digit 0
      press1(0, 1'b0, 16'h1235, 1'b0);

      // all four at once from ptr=0: commits 3 cycles apart
      do_reset();
      @(negedge clk);
      bus.btn_db = 4'b1111;
      expect_upd(2'd0, 1'b0, 16'h1235, 4);
      expect_upd(2'd1, 1'b0, 16'h1245, 7);
      expect_upd(2'd2, 1'b0, 16'h1345, 10);
      expect_upd(2'd3, 1'b0, 16'h2345, 13);
      @(negedge clk);
      bus.btn_db = 4'b0000;
      @(negedge clk);
      chk("busy_grant", 32'(bus.busy), 32'h1);
      repeat (14) @(negedge clk);
      chk("num_all4", 32'(bus.num), 32'h2345);

      // decimal wrap of 9
      press1(0, 1'b0, 16'h2346, 1'b0);
      press1(0, 1'b0, 16'h2347, 1'b0);
      press1(0, 1'b0, 16'h2348, 1'b0);
      press1(0, 1'b0, 16'h2349, 1'b0);
      press1(0, 1'b1, 16'h2340, 1'b1);

      // hex walk of digit 1 through F and wrap
      for (int k = 0; k < 11; k++) begin
         press1(1, 1'b0, 16'h2300 | 16'((5 + k) << 4), 1'b0);
      end
      press1(1, 1'b0, 16'h2300, 1'b1);

      // re-press of btn 2 while its commit is in flight
      @(negedge clk);
      bus.btn_db = 4'b0100;
      expect_upd(2'd2, 1'b0, 16'h2400, 4);
      expect_upd(2'd2, 1'b0, 16'h2500, 7);
      @(negedge clk);
      bus.btn_db = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      chk("busy_commit", 32'(bus.busy), 32'h1);
      bus.btn_db = 4'b0100;
      @(negedge clk);
      bus.btn_db = 4'b0000;
      repeat (6) @(negedge clk);
      chk("num_double", 32'(bus.num), 32'h2500);

      // clr during LOAD discards the update
      @(negedge clk);
      bus.btn_db = 4'b1000;
      @(negedge clk);
      bus.btn_db = 4'b0000;
      @(negedge clk);
      chk("busy_load", 32'(bus.busy), 32'h1);
      bus.clr = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      chk("clr_num", 32'(bus.num), 32'h0);
      chk("clr_busy", 32'(bus.busy), 32'h0);
      chk("clr_upd_valid", 32'(bus.upd_valid), 32'h0);
      repeat (6) @(negedge clk);
      press1(0, 1'b0, 16'h0001, 1'b0);

      // rst during COMMIT aborts the write
      @(negedge clk);
      bus.btn_db = 4'b0010;
      @(negedge clk);
      bus.btn_db = 4'b0000;
      @(negedge clk);
      @(negedge clk);
      rst        = 1'b1;
      bus.btn_db = 4'b0010;
      #1;
      chk("rst_mid_num", 32'(bus.num), 32'h1234);
      chk("rst_mid_busy", 32'(bus.busy), 32'h0);
      chk("rst_mid_upd_valid", 32'(bus.upd_valid), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // button held through reset must not request
      repeat (6) @(negedge clk);
      chk("held_num", 32'(bus.num), 32'h1234);
      chk("held_busy", 32'(bus.busy), 32'h0);
      bus.btn_db = 4'b0000;
      @(negedge clk);
      bus.btn_db = 4'b0010;
      expect_upd(2'd1, 1'b0, 16'h1244, 4);
      @(negedge clk);
      bus.btn_db = 4'b0000;
      repeat (6) @(negedge clk);

      chk("sb_drained", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/score_update_arbiter.md
SCORE_UPDATE_ARBITER -- requirements
Module: score_update_arbiter

Interface
REQ-001 Parameter RESET_VAL, default 16'h1234, is the value of num after reset.
REQ-002 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port btn_db, input, 4 bits: debounced button levels; bit i requests an increment of digit i.
REQ-005 Port mode_dec, input, 1 bit: 1 = decimal digit wrap, 0 = hex digit wrap.
REQ-006 Port clr, input, 1 bit: synchronous clear request.
REQ-007 Port num, output, 16 bits: four 4-bit digits; digit i = num[4i+3:4i]; registered.
REQ-008 Port busy, output, 1 bit: high when the FSM is not in IDLE.
REQ-009 Port upd_valid, output, 1 bit: one-cycle pulse when a digit is written.
REQ-010 Port upd_idx, output, 2 bits: index of the digit written; valid while upd_valid=1.
REQ-011 Port wrap, output, 1 bit: high with upd_valid when the written digit wrapped to 0.

Function
REQ-012 btn_db SHALL be registered into btn_q each cycle; rise[i] = btn_db[i] & ~btn_q[i].
REQ-013 A rise[i] SHALL set pend[i] on the next edge; repeated rises on an already-pending bit merge into one request.
REQ-014 FSM states SHALL be IDLE, LOAD, COMMIT; the reset state is IDLE.
REQ-015 IDLE: if pend != 0, grant g = first set bit of pend searching upward from ptr, modulo 4; latch g; go to LOAD. Otherwise stay in IDLE.
REQ-016 LOAD: operand <= digit[g]; go to COMMIT.
REQ-017 COMMIT: digit[g] <= inc(operand); clear pend[g]; ptr <= g+1 mod 4; assert upd_valid, upd_idx=g, wrap; go to IDLE.
REQ-018 Hex mode: inc(x) = x+1 mod 16, so F wraps to 0 with wrap=1.
REQ-019 Decimal mode: inc(x) = x+1 for x<9; for x>=9 (including A-F), inc(x) = 0 with wrap=1.
REQ-020 mode_dec SHALL be sampled in COMMIT.
REQ-021 A request is served 3 cycles after its grant cycle at the latest; a single request from an idle state gives upd_valid 4 cycles after btn_db rises.
REQ-022 If rise[g] and the pend[g] clear coincide in COMMIT, set wins, so the new request stays pending.
REQ-023 Round-robin SHALL guarantee each pending request is served within 4 updates.
REQ-024 clr=1 SHALL, on the next edge, set num=16'h0000, clear pend, and return the FSM to IDLE with upd_valid=0. ptr is unchanged, and an in-flight update is discarded. clr has priority over all other events.
REQ-025 Only digit g SHALL change on a commit; other digits hold.

Reset
REQ-026 When rst=1, immediately: num=RESET_VAL, pend=0, btn_q=0, ptr=0, state=IDLE, busy=0, upd_valid=0, upd_idx=0, wrap=0.
REQ-027 Reset asserted mid-operation SHALL abort it; no write occurs.
REQ-028 After rst deasserts, a btn_db already held high SHALL NOT generate a request until it falls and rises again.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding, the digit width (4), the digit count (4), and the default RESET_VAL.
REQ-030 The round-robin selector SHALL be one sub-module, rr_arb4: inputs pend[3:0] and ptr[1:0]; outputs grant index and grant valid.

Verification
REQ-031 Reset, then btn_db[0] rises once -> upd_valid 4 cycles later, upd_idx=0, num=16'h1235, wrap=0.
REQ-032 All four btn_db bits rise in the same cycle with ptr=0 -> commits in order 0,1,2,3, each 3 cycles apart, num=16'h2345.
REQ-033 mode_dec=1, digit 0 = 9, press btn 0 -> digit 0 = 0, wrap=1; mode_dec=0, digit = F -> 0, wrap=1.
REQ-034 Second rise on btn 2 during its COMMIT cycle -> two upd_valid pulses for idx 2, and digit 2 advances by 2.
REQ-035 clr asserted during LOAD -> num=0, no upd_valid, busy=0 next cycle; rst asserted mid-COMMIT -> num=RESET_VAL immediately.
